// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Runs one valid/ready data-bus transaction per load/store.
//                Steers store bytes onto lanes, builds write strobes,
//                extracts and sign/zero-extends load data, and returns a
//                one-cycle done pulse qualified by misaligned / bus_err.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // Counter wide enough to hold TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    // RV32I width codes
    localparam logic [2:0] C_F3_B  = 3'b000;
    localparam logic [2:0] C_F3_H  = 3'b001;
    localparam logic [2:0] C_F3_W  = 3'b010;
    localparam logic [2:0] C_F3_BU = 3'b100;
    localparam logic [2:0] C_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [1:0]        addr_lo_q,     addr_lo_d;
    logic [2:0]        funct3_q,      funct3_d;
    logic              mem_we_q,      mem_we_d;
    logic [31:0]       mem_addr_q,    mem_addr_d;
    logic [31:0]       mem_wdata_q,   mem_wdata_d;
    logic [3:0]        mem_wstrb_q,   mem_wstrb_d;
    logic [31:0]       load_result_q, load_result_d;
    logic              misaligned_q,  misaligned_d;
    logic              bus_err_q,     bus_err_d;

    logic              w_req_legal;
    logic              w_req_misaligned;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic [7:0]        w_rd_byte;
    logic [15:0]       w_rd_half;
    logic [31:0]       w_load_ext;
    logic [CNT_W-1:0]  w_cnt_inc;

    // Request qualification: exactly one direction and a legal width code.
    always_comb begin
        w_req_legal = 1'b0;
        if (is_load && !is_store) begin
            w_req_legal = (funct3 == C_F3_B)  || (funct3 == C_F3_H)  ||
                          (funct3 == C_F3_W)  || (funct3 == C_F3_BU) ||
                          (funct3 == C_F3_HU);
        end else if (is_store && !is_load) begin
            w_req_legal = (funct3 == C_F3_B) || (funct3 == C_F3_H) ||
                          (funct3 == C_F3_W);
        end
    end

    // Alignment and store lane steering; funct3[1:0] encodes the access size.
    always_comb begin
        w_req_misaligned = 1'b0;
        w_wdata          = store_data;
        w_wstrb          = 4'b0000;
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_wstrb = 4'b0001 << address[1:0];
            end
            2'b01: begin
                w_req_misaligned = address[0];
                w_wdata          = {2{store_data[15:0]}};
                w_wstrb          = address[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_req_misaligned = (address[1:0] != 2'b00);
                w_wdata          = store_data;
                w_wstrb          = 4'b1111;
            end
        endcase
        if (!is_store) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load lane extraction and extension, using the request's latched offset.
    always_comb begin
        case (addr_lo_q)
            2'd0:    w_rd_byte = mem_rdata[7:0];
            2'd1:    w_rd_byte = mem_rdata[15:8];
            2'd2:    w_rd_byte = mem_rdata[23:16];
            default: w_rd_byte = mem_rdata[31:24];
        endcase
        w_rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            C_F3_B:  w_load_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
            C_F3_H:  w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
            C_F3_BU: w_load_ext = {24'd0, w_rd_byte};
            C_F3_HU: w_load_ext = {16'd0, w_rd_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // Next-state logic. A misaligned request still passes through REQ (with
    // mem_valid held low) so its done pulse lands on the same cycle as a
    // zero-wait aligned access.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_lo_d     = addr_lo_q;
        funct3_d      = funct3_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        load_result_d = load_result_q;
        misaligned_d  = misaligned_q;
        bus_err_d     = bus_err_q;
        w_cnt_inc     = cnt_q + C_CNT_ONE;

        case (state_q)
            S_IDLE: begin
                if (start && w_req_legal) begin
                    addr_lo_d    = address[1:0];
                    funct3_d     = funct3;
                    mem_we_d     = is_store;
                    mem_addr_d   = {address[31:2], 2'b00};
                    mem_wdata_d  = w_wdata;
                    mem_wstrb_d  = w_wstrb;
                    misaligned_d = w_req_misaligned;
                    bus_err_d    = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (misaligned_q) begin
                    state_d = S_RESP;
                end else if (mem_ready) begin
                    if (!mem_we_q) begin
                        load_result_d = w_load_ext;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == C_TIMEOUT) begin
                        bus_err_d = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_lo_q     <= 2'b00;
            funct3_q      <= 3'b000;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            mem_wstrb_q   <= 4'b0000;
            load_result_q <= 32'd0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_lo_q     <= addr_lo_d;
            funct3_q      <= funct3_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            load_result_q <= load_result_d;
            misaligned_q  <= misaligned_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_RESP);
    assign mem_valid   = (state_q == S_REQ) && !misaligned_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign load_result = load_result_q;
    assign misaligned  = misaligned_q;
    assign bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit with
//                hand-computed expected values (TIMEOUT = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_result;
    logic        misaligned;
    logic        bus_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Per-transaction observations
    int          t_done_cyc;
    int          t_valid_cycles;
    logic        t_stable;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_wstrb;
    logic        t_we;
    logic [31:0] t_lr;
    logic        t_mis;
    logic        t_err;
    logic        t_done_after;
    int          hits;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .address     (address),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .load_result (load_result),
        .misaligned  (misaligned),
        .bus_err     (bus_err),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to done. Called just after a rising
    // edge. mem_ready is low for the first 'waits' REQ edges, then high.
    // In cycle 'poke_cyc' a competing store request is driven on start.
    task automatic xact(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int waits, input int poke_cyc);
        int   cyc;
        logic seen;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        address    = addr;
        store_data = sd;
        mem_rdata  = rd;
        mem_ready  = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
        t_done_cyc     = -1;
        t_valid_cycles = 0;
        t_stable       = 1'b1;
        seen           = 1'b0;
        cyc            = 1;
        while (t_done_cyc < 0 && cyc <= 40) begin
            mem_ready = (cyc > waits);
            if (cyc == poke_cyc) begin
                start      = 1'b1;
                is_load    = 1'b0;
                is_store   = 1'b1;
                funct3     = 3'b010;
                address    = 32'h0000_5000;
                store_data = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (mem_valid) begin
                if (!seen) begin
                    t_addr  = mem_addr;
                    t_wdata = mem_wdata;
                    t_wstrb = mem_wstrb;
                    t_we    = mem_we;
                    seen    = 1'b1;
                end else if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !==
                             {t_addr, t_wdata, t_wstrb, t_we}) begin
                    t_stable = 1'b0;
                end
                t_valid_cycles++;
            end
            if (done) begin
                t_done_cyc = cyc;
                t_lr       = load_result;
                t_mis      = misaligned;
                t_err      = bus_err;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start        = 1'b0;
        mem_ready    = 1'b0;
        t_done_after = done;
    endtask

    // Count cycles in which the unit shows any activity.
    task automatic idle_watch(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy || done || mem_valid) h++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        address    = 32'd0;
        store_data = 32'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;
        t_addr     = 32'd0;
        t_wdata    = 32'd0;
        t_wstrb    = 4'd0;
        t_we       = 1'b0;
        t_lr       = 32'd0;
        t_mis      = 1'b0;
        t_err      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", 32'({busy, done, misaligned, bus_err, mem_valid, mem_we, mem_wstrb}), 32'd0);
        check_eq("rst_load_result", load_result, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // LW zero-wait
        xact(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0, 0);
        check_eq("lw_done_cyc", 32'(t_done_cyc), 32'd2);
        check_eq("lw_mem_addr", t_addr, 32'h0000_1000);
        check_eq("lw_wstrb_we", 32'({t_wstrb, t_we}), 32'd0);
        check_eq("lw_valid_cycles", 32'(t_valid_cycles), 32'd1);
        check_eq("lw_result", t_lr, 32'hDEAD_BEEF);
        check_eq("lw_flags", 32'({t_mis, t_err}), 32'd0);
        check_eq("lw_done_pulse", 32'({t_done_after, busy}), 32'd0);

        // LB / LBU from top byte
        xact(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 0);
        check_eq("lb_mem_addr", t_addr, 32'h0000_1000);
        check_eq("lb_result", t_lr, 32'hFFFF_FF80);
        xact(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 0);
        check_eq("lbu_result", t_lr, 32'h0000_0080);

        // LH upper half / LHU lower half
        xact(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'd0, 32'h8001_7FFF, 1, 0);
        check_eq("lh_result", t_lr, 32'hFFFF_8001);
        check_eq("lh_done_cyc", 32'(t_done_cyc), 32'd3);
        xact(1'b1, 1'b0, 3'b101, 32'h0000_1000, 32'd0, 32'h8001_F00F, 0, 0);
        check_eq("lhu_result", t_lr, 32'h0000_F00F);

        // SH with 3 wait cycles
        xact(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 3, 0);
        check_eq("sh_mem_addr", t_addr, 32'h0000_2000);
        check_eq("sh_wdata", t_wdata, 32'hABCD_ABCD);
        check_eq("sh_wstrb_we", 32'({t_wstrb, t_we}), 32'b1100_1);
        check_eq("sh_stable", 32'(t_stable), 32'd1);
        check_eq("sh_valid_cycles", 32'(t_valid_cycles), 32'd4);
        check_eq("sh_done_cyc", 32'(t_done_cyc), 32'd5);
        check_eq("sh_result_held", t_lr, 32'h0000_F00F);

        // SW
        xact(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'd0, 0, 0);
        check_eq("sw_wdata", t_wdata, 32'h1122_3344);
        check_eq("sw_wstrb", 32'(t_wstrb), 32'hF);

        // Misaligned LW
        xact(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'd0, 32'h0BAD_0BAD, 0, 0);
        check_eq("mis_valid_cycles", 32'(t_valid_cycles), 32'd0);
        check_eq("mis_done_cyc", 32'(t_done_cyc), 32'd2);
        check_eq("mis_flags", 32'({t_mis, t_err}), 32'b10);
        check_eq("mis_result_held", t_lr, 32'h0000_F00F);

        // Timeout with mem_ready stuck low
        xact(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 32'h1111_1111, 1000, 0);
        check_eq("to_valid_cycles", 32'(t_valid_cycles), 32'd4);
        check_eq("to_done_cyc", 32'(t_done_cyc), 32'd5);
        check_eq("to_flags", 32'({t_mis, t_err}), 32'b01);
        check_eq("to_result_held", t_lr, 32'h0000_F00F);

        // SB at offset 1; also clears bus_err
        xact(1'b0, 1'b1, 3'b000, 32'h0000_4001, 32'h0000_00A5, 32'd0, 0, 0);
        check_eq("sb_wdata", t_wdata, 32'hA5A5_A5A5);
        check_eq("sb_wstrb", 32'(t_wstrb), 32'b0010);
        check_eq("sb_flags", 32'({t_mis, t_err}), 32'd0);

        // Illegal requests are ignored
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; end
                1:       begin is_load = 1'b1; is_store = 1'b0; funct3 = 3'b011; end
                default: begin is_load = 1'b0; is_store = 1'b1; funct3 = 3'b100; end
            endcase
            address = 32'h0000_7000;
            start   = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            idle_watch(2, hits);
            check_eq("illegal_ignored", 32'(hits), 32'd0);
        end

        // start while busy is ignored
        xact(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'h0BAD_F00D, 3, 2);
        check_eq("busy_start_done_cyc", 32'(t_done_cyc), 32'd5);
        check_eq("busy_start_stable", 32'({t_stable, t_we}), 32'b10);
        check_eq("busy_start_result", t_lr, 32'h0BAD_F00D);
        idle_watch(4, hits);
        check_eq("busy_start_no_second", 32'(hits), 32'd0);

        // start coinciding with done is ignored
        xact(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'd0, 32'h1357_9BDF, 0, 2);
        check_eq("resp_start_result", t_lr, 32'h1357_9BDF);
        idle_watch(4, hits);
        check_eq("resp_start_no_second", 32'(hits), 32'd0);

        // Reset in the middle of REQ
        is_load   = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'b010;
        address   = 32'h0000_6000;
        mem_ready = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("rstmid_valid_before", 32'(mem_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstmid_valid_drop", 32'({mem_valid, busy}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rstmid_outputs", 32'({done, misaligned, bus_err, mem_we, mem_wstrb}), 32'd0);
        check_eq("rstmid_addr_result", mem_addr | load_result | mem_wdata, 32'd0);
        idle_watch(5, hits);
        check_eq("rstmid_no_done", 32'(hits), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
